// File: rtl/fetch_pkg.sv
// Shared types and default constants for the fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
    localparam int          DEFAULT_TIMEOUT  = 64;
    localparam int          DEFAULT_CNT_W    = 7;

endpackage

// File: rtl/fetch_timer.sv
// Fetch-wait counter: counts FETCH cycles without a memory response.
module fetch_timer #(
    parameter int CNT_W   = 7,
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expired marks the last FETCH cycle the stage may wait.
    assign expired = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the architectural PC, fetches over req/valid imem and
// issues each instruction to decode with a stall handshake.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          TIMEOUT  = DEFAULT_TIMEOUT,
    parameter int          CNT_W    = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_next,
    input  logic        halt_decoded,
    input  logic        stall_in,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] pc_cur,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        halted,
    output logic        fetch_err,
    output logic [15:0] retired
);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic [15:0] retired_q, retired_d;
    logic        timer_clr, timer_en, timer_expired;

    fetch_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        err_d     = err_q;
        retired_d = retired_q;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state_q)
            IDLE: begin
                timer_clr = 1'b1;
                state_d   = FETCH;
            end
            FETCH: begin
                // A response on the timeout cycle still wins.
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = ISSUE;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ISSUE: begin
                if (!stall_in) begin
                    retired_d = retired_q + 16'd1;
                    if (halt_decoded) begin
                        state_d = HALT;
                    end else if (pc_next[0]) begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d      = pc_next;
                        timer_clr = 1'b1;
                        state_d   = FETCH;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 16'h0000;
            err_q     <= 1'b0;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            err_q     <= err_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == ISSUE);
    assign halted      = (state_q == HALT);
    assign imem_addr   = pc_q;
    assign pc_cur      = pc_q;
    assign instr       = instr_q;
    assign fetch_err   = err_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a memory model and an instruction scoreboard.
module tb_fetch_unit;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_next = 16'h0000;
    logic        halt_decoded = 1'b0;
    logic        stall_in = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        imem_valid = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] pc_cur;
    logic [15:0] instr;
    logic        instr_valid;
    logic        halted;
    logic        fetch_err;
    logic [15:0] retired;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_pc;
    logic [15:0] exp_ret;
    logic [15:0] cur_instr;

    fetch_unit #(
        .RESET_PC (16'h0000),
        .TIMEOUT  (TIMEOUT),
        .CNT_W    (7)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_next      (pc_next),
        .halt_decoded (halt_decoded),
        .stall_in     (stall_in),
        .imem_rdata   (imem_rdata),
        .imem_valid   (imem_valid),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .pc_cur       (pc_cur),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .fetch_err    (fetch_err),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        return addr ^ 16'hA5C3;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Assert reset mid-cycle, check asynchronous clear, release, land in FETCH.
    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_pc", pc_cur, 16'h0000);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_req", {15'd0, imem_req}, 16'd0);
        chk("rst_ivalid", {15'd0, instr_valid}, 16'd0);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        chk("rst_err", {15'd0, fetch_err}, 16'd0);
        chk("rst_retired", retired, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        imem_valid = 1'b0;
        halt_decoded = 1'b0;
        exp_pc = 16'h0000;
        exp_ret = 16'h0000;
        sb.delete();
        step();
    endtask

    // Called at a negedge in FETCH; waits 'lat' empty cycles then responds.
    task automatic do_fetch(input int lat);
        chk("fetch_req", {15'd0, imem_req}, 16'd1);
        chk("fetch_addr", imem_addr, exp_pc);
        for (int i = 0; i < lat; i++) begin
            imem_valid = 1'b0;
            step();
        end
        imem_valid = 1'b1;
        imem_rdata = mem_word(exp_pc);
        sb.push_back(mem_word(exp_pc));
        step();
        imem_valid = 1'b0;
        imem_rdata = 16'(($urandom));
    endtask

    // Called at a negedge in ISSUE.
    task automatic do_issue(input int stalls, input logic halt, input logic [15:0] nxt);
        logic exp_err;
        chk("issue_valid", {15'd0, instr_valid}, 16'd1);
        cur_instr = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
        chk("issue_instr", instr, cur_instr);
        for (int i = 0; i < stalls; i++) begin
            stall_in = 1'b1;
            halt_decoded = 1'b1;
            pc_next = 16'h0013;
            imem_valid = 1'b1;
            step();
            imem_valid = 1'b0;
            chk("stall_valid", {15'd0, instr_valid}, 16'd1);
            chk("stall_instr", instr, cur_instr);
            chk("stall_pc", pc_cur, exp_pc);
            chk("stall_retired", retired, exp_ret);
        end
        stall_in = 1'b0;
        halt_decoded = halt;
        pc_next = nxt;
        step();
        halt_decoded = 1'b0;
        exp_ret = exp_ret + 16'd1;
        chk("retired", retired, exp_ret);
        if (halt || nxt[0]) begin
            exp_err = !halt;
            chk("halt_halted", {15'd0, halted}, 16'd1);
            chk("halt_err", {15'd0, fetch_err}, {15'd0, exp_err});
            chk("halt_pc", pc_cur, exp_pc);
            chk("halt_req", {15'd0, imem_req}, 16'd0);
        end else begin
            exp_pc = nxt;
            chk("next_pc", pc_cur, exp_pc);
            chk("next_req", {15'd0, imem_req}, 16'd1);
            chk("next_halted", {15'd0, halted}, 16'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_pc = 16'h0000;
        exp_ret = 16'h0000;

        // Sequential run with 1-cycle memory, then a stalled HLT at 0x0006.
        apply_reset();
        do_fetch(1); do_issue(0, 1'b0, 16'h0002);
        do_fetch(1); do_issue(0, 1'b0, 16'h0004);
        do_fetch(1); do_issue(0, 1'b0, 16'h0006);
        chk("retired3", retired, 16'd3);
        do_fetch(0); do_issue(3, 1'b1, 16'h0008);
        chk("hlt_pc6", pc_cur, 16'h0006);
        for (int i = 0; i < 4; i++) begin
            imem_valid = 1'b1;
            halt_decoded = 1'b1;
            pc_next = 16'h0020;
            step();
            chk("absorb_halted", {15'd0, halted}, 16'd1);
            chk("absorb_req", {15'd0, imem_req}, 16'd0);
            chk("absorb_pc", pc_cur, 16'h0006);
        end
        imem_valid = 1'b0;
        halt_decoded = 1'b0;

        // Wrap 0xFFFE -> 0x0000, then a misaligned target.
        apply_reset();
        do_fetch(0); do_issue(0, 1'b0, 16'hFFFE);
        do_fetch(0); do_issue(0, 1'b0, 16'h0000);
        chk("wrap_pc", pc_cur, 16'h0000);
        do_fetch(2); do_issue(0, 1'b0, 16'h0013);
        chk("misalign_pc", pc_cur, 16'h0000);

        // Memory never answers: error exactly TIMEOUT cycles after FETCH entry.
        apply_reset();
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        chk("to_pre_halted", {15'd0, halted}, 16'd0);
        chk("to_pre_req", {15'd0, imem_req}, 16'd1);
        step();
        chk("to_halted", {15'd0, halted}, 16'd1);
        chk("to_err", {15'd0, fetch_err}, 16'd1);
        chk("to_pc", pc_cur, 16'h0000);

        // Response on the TIMEOUT-th cycle beats the timeout.
        apply_reset();
        do_fetch(TIMEOUT - 1);
        chk("late_err", {15'd0, fetch_err}, 16'd0);
        do_issue(0, 1'b0, 16'h0010);

        // Reset in the middle of FETCH at 0x0010.
        step();
        step();
        chk("midfetch_pc", pc_cur, 16'h0010);
        apply_reset();
        do_fetch(0);

        // Reset during a stalled ISSUE.
        stall_in = 1'b1;
        step();
        step();
        chk("stall_hold_valid", {15'd0, instr_valid}, 16'd1);
        apply_reset();
        stall_in = 1'b0;
        do_fetch(0);
        do_issue(0, 1'b0, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
